// File: rtl/hazard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_if
//
// Bundles the pipeline-side signals of the hazard controller. The pipeline
// stages drive the register numbers, write enables and instruction class
// flags. The hazard unit drives back the stall, flush, forwarding and
// mult/div busy indications.
//
// Modports
//   master : pipeline side. Drives the stage information and observes the
//            hazard controls.
//   slave  : hazard unit side. Observes the stage information and drives the
//            hazard controls.
//
// Signal summary
//   rs_decode, rt_decode                [4:0] source registers in decode
//   rs_execute, rt_execute              [4:0] source registers in execute
//   write_register_{execute,memory,writeback}  [4:0] destination registers
//   register_write_{execute,memory,writeback}        write enables
//   memory_to_register_{execute,memory}              stage holds a load
//   branch_decode        decode holds a branch compared in decode
//   muldiv_decode        decode holds mult/multu/div/divu
//   hilo_read_decode     decode holds mfhi/mflo
//   muldiv_start_execute execute starts the mult/div unit this cycle
//   muldiv_is_div_execute the started operation is a divide
//   stall_fetch, stall_decode  hold PC and the fetch/decode register
//   flush_execute        clear of the decode/execute register
//   forward_a_decode, forward_b_decode    comparator operand selects
//   forward_a_execute, forward_b_execute  [1:0] ALU operand selects
//   muldiv_busy          mult/div result pending
// ---------------------------------------------------------------------------
interface hazard_unit_if;
    logic [4:0] rs_decode;
    logic [4:0] rt_decode;
    logic [4:0] rs_execute;
    logic [4:0] rt_execute;
    logic [4:0] write_register_execute;
    logic [4:0] write_register_memory;
    logic [4:0] write_register_writeback;
    logic       register_write_execute;
    logic       register_write_memory;
    logic       register_write_writeback;
    logic       memory_to_register_execute;
    logic       memory_to_register_memory;
    logic       branch_decode;
    logic       muldiv_decode;
    logic       hilo_read_decode;
    logic       muldiv_start_execute;
    logic       muldiv_is_div_execute;

    logic       stall_fetch;
    logic       stall_decode;
    logic       flush_execute;
    logic       forward_a_decode;
    logic       forward_b_decode;
    logic [1:0] forward_a_execute;
    logic [1:0] forward_b_execute;
    logic       muldiv_busy;

    modport master (
        output rs_decode, rt_decode, rs_execute, rt_execute,
        output write_register_execute, write_register_memory, write_register_writeback,
        output register_write_execute, register_write_memory, register_write_writeback,
        output memory_to_register_execute, memory_to_register_memory,
        output branch_decode, muldiv_decode, hilo_read_decode,
        output muldiv_start_execute, muldiv_is_div_execute,
        input  stall_fetch, stall_decode, flush_execute,
        input  forward_a_decode, forward_b_decode,
        input  forward_a_execute, forward_b_execute,
        input  muldiv_busy
    );

    modport slave (
        input  rs_decode, rt_decode, rs_execute, rt_execute,
        input  write_register_execute, write_register_memory, write_register_writeback,
        input  register_write_execute, register_write_memory, register_write_writeback,
        input  memory_to_register_execute, memory_to_register_memory,
        input  branch_decode, muldiv_decode, hilo_read_decode,
        input  muldiv_start_execute, muldiv_is_div_execute,
        output stall_fetch, stall_decode, flush_execute,
        output forward_a_decode, forward_b_decode,
        output forward_a_execute, forward_b_execute,
        output muldiv_busy
    );
endinterface

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//
// Hazard controller for the five-stage MIPS pipeline. It detects the
// following conditions and drives stall and flush for them:
//   - load-use dependencies,
//   - branches whose comparator operands are not yet available,
//   - HI/LO readers or new mult/div operations issued while the mult/div
//     unit is busy.
// It also selects operand forwarding for the decode comparator and the
// execute ALU. A down-counter models the in-flight mult/div latency.
//
// Parameters
//   MULT_LATENCY  cycles until a mult/multu result is in HI/LO (>= 1)
//   DIV_LATENCY   cycles until a div/divu result is in HI/LO (>= MULT_LATENCY)
//
// Ports
//   clk      core clock, rising edge
//   reset_n  asynchronous active-low reset; forces every output to 0 while low
//   hz       hazard_unit_if.slave, holding the stage information in and the
//            hazard controls out
//
// All outputs are combinational from the stage information and the counter.
// None of them feeds back into an input.
// ---------------------------------------------------------------------------
module hazard_unit #(
    parameter int MULT_LATENCY = 4,
    parameter int DIV_LATENCY  = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    hazard_unit_if.slave  hz
);

    localparam int COUNT_W = $clog2(DIV_LATENCY + 1);
    localparam logic [COUNT_W-1:0] MULT_LOAD = COUNT_W'(MULT_LATENCY);
    localparam logic [COUNT_W-1:0] DIV_LOAD  = COUNT_W'(DIV_LATENCY);

    generate
        if (MULT_LATENCY < 1) begin : g_bad_mult_latency
            $error("hazard_unit: MULT_LATENCY must be at least 1");
        end
        if (DIV_LATENCY < MULT_LATENCY) begin : g_bad_div_latency
            $error("hazard_unit: DIV_LATENCY must not be below MULT_LATENCY");
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Register-match detection. Index 0 is the rs operand and index 1 is the
    // rt operand. Register $0 is hard-wired to zero, so it never matches.
    // -----------------------------------------------------------------------
    logic [1:0][4:0] src_decode;
    logic [1:0][4:0] src_execute;

    assign src_decode[0]  = hz.rs_decode;
    assign src_decode[1]  = hz.rt_decode;
    assign src_execute[0] = hz.rs_execute;
    assign src_execute[1] = hz.rt_execute;

    logic [1:0] match_decode_execute;    // decode operand written by execute
    logic [1:0] match_decode_memory;     // decode operand written by memory
    logic [1:0] match_execute_memory;    // execute operand written by memory
    logic [1:0] match_execute_writeback; // execute operand written by writeback

    logic [1:0][1:0] forward_execute_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            assign match_decode_execute[gi] = hz.register_write_execute
                                              && (hz.write_register_execute == src_decode[gi])
                                              && (src_decode[gi] != 5'd0);

            assign match_decode_memory[gi] = hz.register_write_memory
                                             && (hz.write_register_memory == src_decode[gi])
                                             && (src_decode[gi] != 5'd0);

            assign match_execute_memory[gi] = hz.register_write_memory
                                              && (hz.write_register_memory == src_execute[gi])
                                              && (src_execute[gi] != 5'd0);

            assign match_execute_writeback[gi] = hz.register_write_writeback
                                                 && (hz.write_register_writeback == src_execute[gi])
                                                 && (src_execute[gi] != 5'd0);

            // The memory stage holds the younger value, so it takes priority
            // over writeback. The encoding 2'b11 can never be produced.
            assign forward_execute_sel[gi] = match_execute_memory[gi]    ? 2'b10 :
                                             match_execute_writeback[gi] ? 2'b01 :
                                                                           2'b00;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Mult/div latency counter. A start is only accepted while the counter
    // is idle. A start that arrives while busy is dropped, and the counter
    // keeps running down. Pipeline stalls never freeze the counter, because
    // the unit runs on its own once it has been started.
    // -----------------------------------------------------------------------
    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] count_next;
    logic               busy;

    always_comb begin
        count_next = count_reg;
        if (count_reg == '0) begin
            if (hz.muldiv_start_execute) begin
                count_next = hz.muldiv_is_div_execute ? DIV_LOAD : MULT_LOAD;
            end
        end else begin
            count_next = count_reg - COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign busy = (count_reg != '0);

    // -----------------------------------------------------------------------
    // Stall sources.
    //
    // Load-use: the decode instruction needs a load result that is only
    // available after the memory stage.
    //
    // Branch: the comparator runs in decode. It cannot use an execute-stage
    // result, and it cannot use a load that is still in memory. An ALU
    // result in memory is forwarded instead of stalling.
    //
    // Mult/div: HI/LO readers and new mult/div ops wait for the pending
    // result. The start cycle counts as well, because the counter only
    // loads at the end of that cycle.
    // -----------------------------------------------------------------------
    logic load_use_stall;
    logic branch_stall;
    logic muldiv_stall;
    logic stall;

    assign load_use_stall = hz.memory_to_register_execute && (|match_decode_execute);

    assign branch_stall = hz.branch_decode
                          && ((|match_decode_execute)
                              || (hz.memory_to_register_memory && (|match_decode_memory)));

    assign muldiv_stall = (busy || hz.muldiv_start_execute)
                          && (hz.hilo_read_decode || hz.muldiv_decode);

    assign stall = load_use_stall || branch_stall || muldiv_stall;

    // -----------------------------------------------------------------------
    // Outputs. Every output is qualified with reset_n, so it drops to 0 as
    // soon as reset is asserted, with no clock edge needed. Flush and both
    // stalls move together. The stalled decode instruction is therefore
    // presented again while a bubble enters execute.
    // -----------------------------------------------------------------------
    assign hz.stall_fetch       = reset_n && stall;
    assign hz.stall_decode      = reset_n && stall;
    assign hz.flush_execute     = reset_n && stall;
    assign hz.forward_a_decode  = reset_n && match_decode_memory[0];
    assign hz.forward_b_decode  = reset_n && match_decode_memory[1];
    assign hz.forward_a_execute = reset_n ? forward_execute_sel[0] : 2'b00;
    assign hz.forward_b_execute = reset_n ? forward_execute_sel[1] : 2'b00;
    assign hz.muldiv_busy       = reset_n && busy;

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed scoreboard bench for hazard_unit. Each stimulus step drives the
// inputs just after a rising edge and pushes the expected output vector
// onto a queue. A monitor pops the queue on the falling edge and compares.
//
// Expected vector layout:
//   {stall_fetch, stall_decode, flush_execute, forward_a_decode,
//    forward_b_decode, forward_a_execute[1:0], forward_b_execute[1:0],
//    muldiv_busy}
// ---------------------------------------------------------------------------
module tb_hazard_unit;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    hazard_unit_if hz ();

    hazard_unit #(
        .MULT_LATENCY (4),
        .DIV_LATENCY  (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_checks = 0;
    int       n_pass   = 0;

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-20s out=%b", tag, got);
        end else begin
            $display("FAIL %-20s got=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] pack_exp(input logic stall, input logic fad, input logic fbd,
                                            input logic [1:0] fae, input logic [1:0] fbe,
                                            input logic busy);
        return {stall, stall, stall, fad, fbd, fae, fbe, busy};
    endfunction

    function automatic logic [9:0] observed();
        return {hz.stall_fetch, hz.stall_decode, hz.flush_execute,
                hz.forward_a_decode, hz.forward_b_decode,
                hz.forward_a_execute, hz.forward_b_execute, hz.muldiv_busy};
    endfunction

    // Scoreboard consumer: one comparison per clock, half a cycle after drive.
    always @(negedge clk) begin : monitor
        sb_item_t item;
        if (sb_q.size() != 0) begin
            item = sb_q.pop_front();
            check_eq(item.tag, observed(), item.exp);
        end
    end

    // Push an expectation for the currently driven inputs and advance one
    // cycle. Returns 1 time unit after the next rising edge.
    task automatic step(input string tag, input logic [9:0] exp);
        sb_q.push_back('{tag: tag, exp: exp});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.rs_decode                  = 5'd0;
        hz.rt_decode                  = 5'd0;
        hz.rs_execute                 = 5'd0;
        hz.rt_execute                 = 5'd0;
        hz.write_register_execute     = 5'd0;
        hz.write_register_memory      = 5'd0;
        hz.write_register_writeback   = 5'd0;
        hz.register_write_execute     = 1'b0;
        hz.register_write_memory      = 1'b0;
        hz.register_write_writeback   = 1'b0;
        hz.memory_to_register_execute = 1'b0;
        hz.memory_to_register_memory  = 1'b0;
        hz.branch_decode              = 1'b0;
        hz.muldiv_decode              = 1'b0;
        hz.hilo_read_decode           = 1'b0;
        hz.muldiv_start_execute       = 1'b0;
        hz.muldiv_is_div_execute      = 1'b0;
    endtask

    localparam logic [9:0] ZERO = 10'b0;

    initial begin
        // Reset held with hazards present and a start pending: everything 0.
        reset_n = 1'b0;
        idle_inputs();
        hz.rs_execute            = 5'd5;
        hz.register_write_memory = 1'b1;
        hz.write_register_memory = 5'd5;
        hz.hilo_read_decode      = 1'b1;
        hz.muldiv_start_execute  = 1'b1;
        @(posedge clk);
        #1;
        step("reset_hold", ZERO);
        step("reset_hold2", ZERO);
        reset_n = 1'b1;
        idle_inputs();
        step("idle", ZERO);

        // Execute forwarding: memory beats writeback, then writeback, then $0.
        hz.rs_execute               = 5'd5;
        hz.register_write_memory    = 1'b1;
        hz.write_register_memory    = 5'd5;
        hz.register_write_writeback = 1'b1;
        hz.write_register_writeback = 5'd5;
        step("fwd_a_mem_prio", pack_exp(0, 0, 0, 2'b10, 2'b00, 0));
        hz.write_register_memory    = 5'd6;
        step("fwd_a_wb", pack_exp(0, 0, 0, 2'b01, 2'b00, 0));
        hz.write_register_memory    = 5'd0;
        hz.write_register_writeback = 5'd0;
        hz.rs_execute               = 5'd0;
        step("fwd_r0_never", ZERO);
        hz.rt_execute               = 5'd7;
        hz.write_register_writeback = 5'd7;
        hz.write_register_memory    = 5'd7;
        hz.register_write_memory    = 1'b0;
        step("fwd_b_wb_only", pack_exp(0, 0, 0, 2'b00, 2'b01, 0));

        // Load-use: one stall cycle, then forward from the memory stage.
        idle_inputs();
        hz.memory_to_register_execute = 1'b1;
        hz.register_write_execute     = 1'b1;
        hz.write_register_execute     = 5'd8;
        hz.rt_decode                  = 5'd8;
        step("load_use_stall", pack_exp(1, 0, 0, 2'b00, 2'b00, 0));
        idle_inputs();
        hz.register_write_memory     = 1'b1;
        hz.write_register_memory     = 5'd8;
        hz.memory_to_register_memory = 1'b1;
        hz.rt_execute                = 5'd8;
        step("load_use_fwd", pack_exp(0, 0, 0, 2'b00, 2'b10, 0));
        idle_inputs();
        hz.memory_to_register_execute = 1'b1;
        hz.register_write_execute     = 1'b1;
        hz.write_register_execute     = 5'd0;
        step("load_use_r0", ZERO);

        // Branch: execute writer stalls, ALU writer in memory forwards,
        // load writer in memory stalls.
        idle_inputs();
        hz.branch_decode          = 1'b1;
        hz.rs_decode              = 5'd3;
        hz.register_write_execute = 1'b1;
        hz.write_register_execute = 5'd3;
        step("branch_exec_stall", pack_exp(1, 0, 0, 2'b00, 2'b00, 0));
        idle_inputs();
        hz.branch_decode         = 1'b1;
        hz.rs_decode             = 5'd3;
        hz.register_write_memory = 1'b1;
        hz.write_register_memory = 5'd3;
        step("branch_mem_alu", pack_exp(0, 1, 0, 2'b00, 2'b00, 0));
        idle_inputs();
        hz.branch_decode             = 1'b1;
        hz.rt_decode                 = 5'd9;
        hz.register_write_memory     = 1'b1;
        hz.write_register_memory     = 5'd9;
        hz.memory_to_register_memory = 1'b1;
        step("branch_mem_load", pack_exp(1, 0, 1, 2'b00, 2'b00, 0));
        hz.branch_decode = 1'b0;
        step("nobranch_mem_load", pack_exp(0, 0, 1, 2'b00, 2'b00, 0));

        // Mult with mfhi waiting. A start while busy must be ignored.
        idle_inputs();
        hz.hilo_read_decode     = 1'b1;
        hz.muldiv_start_execute = 1'b1;
        step("mult_start", pack_exp(1, 0, 0, 2'b00, 2'b00, 0));
        for (int i = 1; i <= 4; i++) begin
            hz.muldiv_start_execute  = (i == 2);
            hz.muldiv_is_div_execute = (i == 2);
            step($sformatf("mult_busy_%0d", i), pack_exp(1, 0, 0, 2'b00, 2'b00, 1));
        end
        hz.muldiv_start_execute  = 1'b0;
        hz.muldiv_is_div_execute = 1'b0;
        step("mult_done", ZERO);

        // Divide with a mult/div op held in decode: 33 stall, 32 busy.
        idle_inputs();
        hz.muldiv_decode         = 1'b1;
        hz.muldiv_start_execute  = 1'b1;
        hz.muldiv_is_div_execute = 1'b1;
        step("div_start", pack_exp(1, 0, 0, 2'b00, 2'b00, 0));
        hz.muldiv_start_execute  = 1'b0;
        hz.muldiv_is_div_execute = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step($sformatf("div_busy_%0d", i), pack_exp(1, 0, 0, 2'b00, 2'b00, 1));
        end
        step("div_done", ZERO);

        // Reset in the middle of a divide, then a fresh mult.
        idle_inputs();
        hz.hilo_read_decode      = 1'b1;
        hz.muldiv_start_execute  = 1'b1;
        hz.muldiv_is_div_execute = 1'b1;
        step("div2_start", pack_exp(1, 0, 0, 2'b00, 2'b00, 0));
        hz.muldiv_start_execute  = 1'b0;
        hz.muldiv_is_div_execute = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step($sformatf("div2_busy_%0d", i), pack_exp(1, 0, 0, 2'b00, 2'b00, 1));
        end
        #1;
        reset_n = 1'b0;
        #1;
        check_eq("async_reset_out", observed(), ZERO);
        #1;
        reset_n = 1'b1;
        // No clock edge occurred during reset, so a cleared counter proves
        // the clear was asynchronous.
        step("after_reset", ZERO);
        hz.hilo_read_decode     = 1'b0;
        hz.muldiv_start_execute = 1'b1;
        step("mult2_start", ZERO);
        hz.muldiv_start_execute = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step($sformatf("mult2_busy_%0d", i), pack_exp(0, 0, 0, 2'b00, 2'b00, 1));
        end
        step("mult2_done", ZERO);

        if (sb_q.size() != 0) begin
            check_eq("sb_drain", 10'(sb_q.size()), ZERO);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
